// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC and drives a 1-cycle-latency instruction SRAM.
// Presents {pc+4, inst, have_inst} to IF/ID and holds the returned instruction across stalls.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  pipeline_stop_i,
  input  logic [1:0]  pipeline_stop_branch_i,
  input  logic [31:0] branch_target_i,
  output logic        inst_sram_en_o,
  output logic [31:0] inst_sram_addr_o,
  input  logic [31:0] inst_sram_rdata_i,
  output logic [31:0] if_pc4_o,
  output logic [31:0] if_inst_o,
  output logic        if_debug_wb_have_inst
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state, state_next;
  logic [31:0] fetch_pc, fetch_pc_next;
  logic [31:0] resp_pc, resp_pc_next;
  logic        resp_valid, resp_valid_next;
  logic [31:0] hold_inst, hold_inst_next;
  logic        hold_valid, hold_valid_next;

  logic        stall;
  logic        redirect;
  logic [31:0] target;

  assign stall    = (pipeline_stop_i != 2'b00);
  assign redirect = (pipeline_stop_branch_i != 2'b00);
  assign target   = {branch_target_i[31:2], 2'b00};

  // NOTE: every output and next-state value gets a default before the case so no latch is inferred.
  always_comb begin
    state_next            = state;
    fetch_pc_next         = fetch_pc;
    resp_pc_next          = resp_pc;
    resp_valid_next       = resp_valid;
    hold_inst_next        = hold_inst;
    hold_valid_next       = hold_valid;
    inst_sram_en_o        = 1'b0;
    inst_sram_addr_o      = fetch_pc;
    if_pc4_o              = 32'h0;
    if_inst_o             = 32'h0;
    if_debug_wb_have_inst = 1'b0;

    unique case (state)
      BOOT: begin
        // State is BOOT throughout reset; gating with rst_n keeps en low while reset is held.
        inst_sram_en_o   = rst_n;
        inst_sram_addr_o = RESET_PC;
        fetch_pc_next    = RESET_PC + 32'd4;
        resp_pc_next     = RESET_PC;
        resp_valid_next  = 1'b1;
        hold_valid_next  = 1'b0;
        state_next       = RUN;
      end

      RUN: begin
        if_pc4_o              = resp_valid ? resp_pc + 32'd4 : 32'h0;
        if_inst_o             = hold_valid ? hold_inst
                              : (resp_valid ? inst_sram_rdata_i : 32'h0);
        if_debug_wb_have_inst = resp_valid & (!redirect | stall);

        if (stall) begin
          // First stall cycle captures the SRAM data; later cycles replay it unchanged.
          if (!hold_valid) begin
            hold_inst_next  = inst_sram_rdata_i;
            hold_valid_next = 1'b1;
          end
        end else if (redirect) begin
          inst_sram_en_o   = 1'b1;
          inst_sram_addr_o = target;
          fetch_pc_next    = target + 32'd4;
          resp_pc_next     = target;
          resp_valid_next  = 1'b1;
          hold_valid_next  = 1'b0;
        end else begin
          inst_sram_en_o   = 1'b1;
          inst_sram_addr_o = fetch_pc;
          fetch_pc_next    = fetch_pc + 32'd4;
          resp_pc_next     = fetch_pc;
          resp_valid_next  = 1'b1;
          hold_valid_next  = 1'b0;
        end
      end

      default: state_next = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      fetch_pc   <= RESET_PC;
      resp_pc    <= 32'h0;
      resp_valid <= 1'b0;
      hold_valid <= 1'b0;
    end else begin
      state      <= state_next;
      fetch_pc   <= fetch_pc_next;
      resp_pc    <= resp_pc_next;
      resp_valid <= resp_valid_next;
      hold_valid <= hold_valid_next;
    end
  end

  // NOTE: hold_inst is pure data qualified by hold_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    hold_inst <= hold_inst_next;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed table-driven bench for if_fetch_unit: boot, stall/hold, redirect, wrap, and reset mid-stall.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [1:0]  pipeline_stop_i;
  logic [1:0]  pipeline_stop_branch_i;
  logic [31:0] branch_target_i;
  logic        inst_sram_en_o;
  logic [31:0] inst_sram_addr_o;
  logic [31:0] inst_sram_rdata_i;
  logic [31:0] if_pc4_o;
  logic [31:0] if_inst_o;
  logic        if_debug_wb_have_inst;

  int checks   = 0;
  int failures = 0;

  if_fetch_unit #(.RESET_PC(32'h8000_0000)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .pipeline_stop_i       (pipeline_stop_i),
    .pipeline_stop_branch_i(pipeline_stop_branch_i),
    .branch_target_i       (branch_target_i),
    .inst_sram_en_o        (inst_sram_en_o),
    .inst_sram_addr_o      (inst_sram_addr_o),
    .inst_sram_rdata_i     (inst_sram_rdata_i),
    .if_pc4_o              (if_pc4_o),
    .if_inst_o             (if_inst_o),
    .if_debug_wb_have_inst (if_debug_wb_have_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  stop;
    logic [1:0]  br;
    logic [31:0] tgt;
    logic [31:0] rdata;
    logic        en;
    logic [31:0] addr;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        have;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic en, input logic [31:0] addr,
                               input logic [31:0] pc4, input logic [31:0] inst, input logic have);
    check({tag, ".en"},   {31'h0, inst_sram_en_o},        {31'h0, en});
    check({tag, ".addr"}, inst_sram_addr_o,               addr);
    check({tag, ".pc4"},  if_pc4_o,                       pc4);
    check({tag, ".inst"}, if_inst_o,                      inst);
    check({tag, ".have"}, {31'h0, if_debug_wb_have_inst}, {31'h0, have});
  endtask

  // Drives one cycle of inputs just after a posedge, checks mid-cycle, then advances.
  task automatic apply(input string tag, input vec_t v);
    pipeline_stop_i        = v.stop;
    pipeline_stop_branch_i = v.br;
    branch_target_i        = v.tgt;
    inst_sram_rdata_i      = v.rdata;
    #1;
    check_outputs(tag, v.en, v.addr, v.pc4, v.inst, v.have);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           stop  br    tgt           rdata         en    addr          pc4           inst          have
    vecs[0]  = '{2'd0, 2'd0, 32'h0,        32'hDEAD0000, 1'b1, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0};
    vecs[1]  = '{2'd0, 2'd0, 32'h0,        32'h11110000, 1'b1, 32'h80000004, 32'h80000004, 32'h11110000, 1'b1};
    vecs[2]  = '{2'd1, 2'd0, 32'h0,        32'h11110004, 1'b0, 32'h80000008, 32'h80000008, 32'h11110004, 1'b1};
    vecs[3]  = '{2'd3, 2'd0, 32'h0,        32'hAAAAAAAA, 1'b0, 32'h80000008, 32'h80000008, 32'h11110004, 1'b1};
    vecs[4]  = '{2'd1, 2'd1, 32'h80000200, 32'h55555555, 1'b0, 32'h80000008, 32'h80000008, 32'h11110004, 1'b1};
    vecs[5]  = '{2'd0, 2'd0, 32'h0,        32'h12345678, 1'b1, 32'h80000008, 32'h80000008, 32'h11110004, 1'b1};
    vecs[6]  = '{2'd0, 2'd0, 32'h0,        32'h22220008, 1'b1, 32'h8000000C, 32'h8000000C, 32'h22220008, 1'b1};
    vecs[7]  = '{2'd0, 2'd2, 32'h80000102, 32'h3333000C, 1'b1, 32'h80000100, 32'h80000010, 32'h3333000C, 1'b0};
    vecs[8]  = '{2'd0, 2'd0, 32'h0,        32'h44440100, 1'b1, 32'h80000104, 32'h80000104, 32'h44440100, 1'b1};
    vecs[9]  = '{2'd2, 2'd1, 32'h80000200, 32'h55550104, 1'b0, 32'h80000108, 32'h80000108, 32'h55550104, 1'b1};
    vecs[10] = '{2'd0, 2'd0, 32'h0,        32'h00000000, 1'b1, 32'h80000108, 32'h80000108, 32'h55550104, 1'b1};
    vecs[11] = '{2'd0, 2'd0, 32'h0,        32'h66660108, 1'b1, 32'h8000010C, 32'h8000010C, 32'h66660108, 1'b1};
    vecs[12] = '{2'd0, 2'd1, 32'hFFFFFFFE, 32'h7777010C, 1'b1, 32'hFFFFFFFC, 32'h80000110, 32'h7777010C, 1'b0};
    vecs[13] = '{2'd0, 2'd0, 32'h0,        32'h8888FFFC, 1'b1, 32'h00000000, 32'h00000000, 32'h8888FFFC, 1'b1};
    vecs[14] = '{2'd0, 2'd0, 32'h0,        32'h99990000, 1'b1, 32'h00000004, 32'h00000004, 32'h99990000, 1'b1};

    rst_n                  = 1'b0;
    pipeline_stop_i        = 2'd0;
    pipeline_stop_branch_i = 2'd0;
    branch_target_i        = 32'h0;
    inst_sram_rdata_i      = 32'h0;

    // Reset held: everything quiet, address parked at RESET_PC.
    @(posedge clk);
    #2;
    check_outputs("reset", 1'b0, 32'h80000000, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      apply($sformatf("v%0d", i), vecs[i]);
    end

    // Reset asserted mid-stall with a held instruction: outputs clear at once.
    apply("t6_stall1", '{2'd1, 2'd0, 32'h0, 32'hCAFE0004, 1'b0, 32'h00000008,
                         32'h00000008, 32'hCAFE0004, 1'b1});
    pipeline_stop_i   = 2'd1;
    inst_sram_rdata_i = 32'h0BAD0BAD;
    #1;
    check_outputs("t6_stall2", 1'b0, 32'h00000008, 32'h00000008, 32'hCAFE0004, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs("t6_async", 1'b0, 32'h80000000, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    pipeline_stop_i = 2'd0;
    #1;
    check_outputs("t6_held", 1'b0, 32'h80000000, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    apply("t6_boot", '{2'd0, 2'd0, 32'h0, 32'h0BAD0BAD, 1'b1, 32'h80000000,
                       32'h0, 32'h0, 1'b0});
    apply("t6_first", '{2'd0, 2'd0, 32'h0, 32'hABCD0000, 1'b1, 32'h80000004,
                        32'h80000004, 32'hABCD0000, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
